// File: rtl/looper_pkg.sv
// Shared types, defaults and the saturating mixer for the phrase looper.
package looper_pkg;

  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_MAX_LEN = 2**DEF_ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_SETUP  = 2'd1,
    A_STROBE = 2'd2,
    A_DONE   = 2'd3
  } phase_t;

  // Adds two signed samples at 17 bits and clamps to the 16-bit range.
  function automatic logic [15:0] sat16(input logic [15:0] live, input logic [15:0] loop_s);
    logic signed [16:0] sum;
    sum = $signed({live[15], live}) + $signed({loop_s[15], loop_s});
    if (sum > 17'sd32767)
      return 16'h7FFF;
    else if (sum < -17'sd32768)
      return 16'h8000;
    else
      return sum[15:0];
  endfunction

endpackage

// File: rtl/looper_sram_if.sv
// SRAM access sequencer: one read or write per request, four phases long,
// plus the DQ tri-state driver. A request with mem=0 only runs the phases
// so every sample sees the same latency.
module looper_sram_if
  import looper_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              req,
  input  logic              req_mem,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic [15:0]       rd_data,
  output logic              done,
  output logic              idle,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  inout  wire  [15:0]       sram_dq
);

  phase_t            phase;
  logic              mem_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              dq_oe;

  assign done    = (phase == A_DONE);
  assign idle    = (phase == A_IDLE);
  assign sram_dq = dq_oe ? wdata_q : 16'bz;

  // Phase sequencer: setup drives address and strobe, strobe phase captures
  // read data and raises WE_N, done phase releases OE_N and the DQ bus.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase     <= A_IDLE;
      mem_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dq_oe     <= 1'b0;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      rd_data   <= '0;
    end else begin
      case (phase)
        A_IDLE: begin
          if (req) begin
            phase   <= A_SETUP;
            mem_q   <= req_mem;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        A_SETUP: begin
          phase <= A_STROBE;
          if (mem_q) begin
            sram_addr <= addr_q;
            if (we_q) begin
              sram_we_n <= 1'b0;
              dq_oe     <= 1'b1;
            end else begin
              sram_oe_n <= 1'b0;
            end
          end
        end
        A_STROBE: begin
          phase     <= A_DONE;
          sram_we_n <= 1'b1;
          if (mem_q && !we_q)
            rd_data <= sram_dq;
        end
        A_DONE: begin
          phase     <= A_IDLE;
          sram_oe_n <= 1'b1;
          dq_oe     <= 1'b0;
        end
        default: phase <= A_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/effect_looper.sv
// Single-track phrase looper: records the processed stream to SRAM and plays
// it back mixed with the live signal.
module effect_looper
  import looper_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_LEN = 2**ADDR_W - 1
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [15:0]       i_data,
  input  logic              i_rec,
  input  logic              i_play,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic [1:0]        o_state,
  output logic [ADDR_W-1:0] o_loop_len,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  inout  wire  [15:0]       io_SRAM_DQ
);

  localparam logic [ADDR_W:0] MAX_LEN_X = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] ONE_X     = (ADDR_W+1)'(1);

  mode_t             state, nxt_state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, loop_len;
  logic [ADDR_W-1:0] nxt_wr, nxt_rd, nxt_len, acc_addr;
  logic [ADDR_W:0]   wr_sum, rd_sum;
  logic              do_write, do_read;
  logic              accept, seq_idle, seq_done;
  logic [15:0]       live_q, rd_data;
  logic              mix_q;

  assign accept      = i_valid && seq_idle;
  assign o_state     = state;
  assign o_loop_len  = loop_len;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;

  // Decide what the current sample does (write, read or pass through) and
  // the resulting mode, pointers and loop length; i_rec wins over i_play.
  always_comb begin
    nxt_state = state;
    nxt_wr    = wr_ptr;
    nxt_rd    = rd_ptr;
    nxt_len   = loop_len;
    do_write  = 1'b0;
    do_read   = 1'b0;
    acc_addr  = '0;
    wr_sum    = '0;
    rd_sum    = '0;
    case (state)
      IDLE: begin
        if (i_rec)
          do_write = 1'b1;
        else if (i_play && loop_len != '0)
          do_read = 1'b1;
      end
      RECORD: begin
        if (i_rec) begin
          do_write = 1'b1;
          acc_addr = wr_ptr;
        end else begin
          nxt_len = wr_ptr;
          if (i_play && wr_ptr != '0)
            do_read = 1'b1;
        end
      end
      PLAY: begin
        if (i_rec) begin
          do_write = 1'b1;
        end else if (i_play) begin
          do_read  = 1'b1;
          acc_addr = rd_ptr;
        end
      end
      default: ;
    endcase
    if (do_write) begin
      nxt_state = RECORD;
      wr_sum    = {1'b0, acc_addr} + ONE_X;
      nxt_wr    = wr_sum[ADDR_W-1:0];
      if (wr_sum == MAX_LEN_X) begin
        nxt_state = PLAY;
        nxt_len   = MAX_LEN_X[ADDR_W-1:0];
        nxt_rd    = '0;
      end
    end else if (do_read) begin
      nxt_state = PLAY;
      rd_sum    = {1'b0, acc_addr} + ONE_X;
      nxt_rd    = (rd_sum == {1'b0, nxt_len}) ? '0 : rd_sum[ADDR_W-1:0];
    end else begin
      nxt_state = IDLE;
    end
  end

  // Mode FSM and pointers advance only on an accepted sample strobe.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      loop_len <= '0;
      live_q   <= '0;
      mix_q    <= 1'b0;
    end else if (accept) begin
      state    <= nxt_state;
      wr_ptr   <= nxt_wr;
      rd_ptr   <= nxt_rd;
      loop_len <= nxt_len;
      live_q   <= i_data;
      mix_q    <= do_read;
    end
  end

  // Output stage: present live or mixed sample when the access completes.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= seq_done;
      if (seq_done)
        o_data <= mix_q ? sat16(live_q, rd_data) : live_q;
    end
  end

  looper_sram_if #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .i_AUD_BCLK(i_AUD_BCLK),
    .i_rst_n   (i_rst_n),
    .req       (accept),
    .req_mem   (do_write || do_read),
    .req_we    (do_write),
    .req_addr  (acc_addr),
    .req_wdata (i_data),
    .rd_data   (rd_data),
    .done      (seq_done),
    .idle      (seq_idle),
    .sram_addr (o_SRAM_ADDR),
    .sram_we_n (o_SRAM_WE_N),
    .sram_oe_n (o_SRAM_OE_N),
    .sram_dq   (io_SRAM_DQ)
  );

endmodule

// File: tb/tb_effect_looper.sv
// Self-checking bench for effect_looper with a small behavioural SRAM.
module tb_effect_looper;

  localparam int ADDR_W  = 20;
  localparam int MAX_LEN = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_rec = 1'b0;
  logic              i_play = 1'b0;
  logic [15:0]       i_data = '0;
  logic [15:0]       o_data;
  logic              o_valid;
  logic [1:0]        o_state;
  logic [ADDR_W-1:0] o_loop_len;
  logic [ADDR_W-1:0] sram_addr;
  logic              we_n, oe_n, ce_n, lb_n, ub_n;
  wire  [15:0]       sram_dq;

  logic [15:0] mem [0:31];

  typedef struct {
    logic rec;
    logic play;
    int   data;
    int   exp_data;
    int   exp_state;
    int   exp_len;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad = 0;
  int overlap = 0;
  int got_data, got_lat, got_cnt, got_acc;
  int exp_acc, wait_cnt;

  effect_looper #(
    .ADDR_W (ADDR_W),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .i_AUD_BCLK (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_rec      (i_rec),
    .i_play     (i_play),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_state    (o_state),
    .o_loop_len (o_loop_len),
    .o_SRAM_ADDR(sram_addr),
    .o_SRAM_WE_N(we_n),
    .o_SRAM_OE_N(oe_n),
    .o_SRAM_CE_N(ce_n),
    .o_SRAM_LB_N(lb_n),
    .o_SRAM_UB_N(ub_n),
    .io_SRAM_DQ (sram_dq)
  );

  always #5 clk = ~clk;

  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[4:0]] : 16'bz;

  // SRAM model latches data on the rising edge of WE_N
  always @(posedge we_n) begin
    if (rst_n)
      mem[sram_addr[4:0]] <= sram_dq;
  end

  // Flag any cycle where both strobes are low
  always @(negedge clk) begin
    if (rst_n && !we_n && !oe_n)
      overlap++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rec, input logic play, input int data);
    @(negedge clk);
    i_rec   = rec;
    i_play  = play;
    i_data  = data[15:0];
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    got_data = 0;
    got_lat  = 0;
    got_cnt  = 0;
    got_acc  = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        got_cnt++;
        if (got_lat == 0) got_lat = c;
        got_data = int'($signed(o_data));
      end
      if (!oe_n) got_acc |= 1;
      if (!we_n) got_acc |= 2;
    end
  endtask

  task automatic addVec(input logic rec, input logic play, input int data,
                        input int exp_data, input int exp_state, input int exp_len);
    vec_t v;
    v.rec = rec; v.play = play; v.data = data;
    v.exp_data = exp_data; v.exp_state = exp_state; v.exp_len = exp_len;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;

    // empty loop and idle passthrough
    addVec(0, 1, 1234, 1234, 0, 0);
    addVec(0, 0, -5, -5, 0, 0);
    // record 100..107
    for (int i = 0; i < 8; i++) addVec(1, 0, 100 + i, 100 + i, 1, 0);
    // stop with play: first played sample is this one
    for (int i = 0; i < 8; i++) addVec(0, 1, 0, 100 + i, 2, 8);
    addVec(0, 1, 0, 100, 2, 8);
    addVec(0, 1, 3, 104, 2, 8);
    addVec(0, 0, 77, 77, 0, 8);
    addVec(0, 1, 0, 100, 2, 8);
    // overwrite with a two-sample loop for saturation
    addVec(1, 1, 30000, 30000, 1, 8);
    addVec(1, 1, -30000, -30000, 1, 8);
    addVec(0, 1, 10000, 32767, 2, 2);
    addVec(0, 1, -10000, -32768, 2, 2);
    addVec(0, 1, -10000, 20000, 2, 2);
    addVec(0, 1, 10000, -20000, 2, 2);

    // reset values
    repeat (3) @(negedge clk);
    checkOutput("rst o_data", int'(o_data), 0);
    checkOutput("rst o_valid", int'(o_valid), 0);
    checkOutput("rst o_state", int'(o_state), 0);
    checkOutput("rst o_loop_len", int'(o_loop_len), 0);
    checkOutput("rst addr", int'(sram_addr), 0);
    checkOutput("rst we_n", int'(we_n), 1);
    checkOutput("rst oe_n", int'(oe_n), 1);
    checkOutput("rst ce_lb_ub", int'({ce_n, lb_n, ub_n}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rec, vecs[i].play, vecs[i].data);
      exp_acc = (vecs[i].exp_state == 0) ? 0 : (vecs[i].exp_state == 1) ? 2 : 1;
      checkOutput($sformatf("vec%0d data", i), got_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d latency", i), got_lat, 3);
      checkOutput($sformatf("vec%0d valid_count", i), got_cnt, 1);
      checkOutput($sformatf("vec%0d state", i), int'(o_state), vecs[i].exp_state);
      checkOutput($sformatf("vec%0d loop_len", i), int'(o_loop_len), vecs[i].exp_len);
      checkOutput($sformatf("vec%0d access", i), got_acc, exp_acc);
    end

    // strobe arriving two cycles after an accepted one is ignored
    @(negedge clk);
    i_rec = 1'b0; i_play = 1'b1; i_data = 16'd0; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    got_cnt = 0;
    got_data = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin
        i_data  = 16'd5000;
        i_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      if (c == 2) i_valid = 1'b0;
      if (o_valid) begin
        got_cnt++;
        got_data = int'($signed(o_data));
      end
    end
    checkOutput("ignored valid_count", got_cnt, 1);
    checkOutput("ignored data", got_data, 30000);
    applyStimulus(0, 1, 0);
    checkOutput("after ignored data", got_data, -30000);

    // full memory: forced PLAY after the MAX_LEN-th write
    for (int i = 0; i < MAX_LEN; i++) begin
      applyStimulus(1, 1, 200 + i);
      checkOutput($sformatf("full%0d data", i), got_data, 200 + i);
      checkOutput($sformatf("full%0d state", i), int'(o_state), (i == MAX_LEN - 1) ? 2 : 1);
      checkOutput($sformatf("full%0d loop_len", i), int'(o_loop_len), (i == MAX_LEN - 1) ? MAX_LEN : 2);
    end
    applyStimulus(0, 1, 0);
    checkOutput("full play0", got_data, 200);
    applyStimulus(0, 1, 0);
    checkOutput("full play1", got_data, 201);
    checkOutput("full play state", int'(o_state), 2);

    // reset while WE_N is low
    @(negedge clk);
    i_rec = 1'b1; i_play = 1'b1; i_data = 16'd999; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_cnt = 0;
    while (we_n && wait_cnt < 5) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    checkOutput("write strobe seen", int'(we_n), 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst we_n", int'(we_n), 1);
    checkOutput("midrst oe_n", int'(oe_n), 1);
    checkOutput("midrst dq_drive", int'(dut.u_sram.dq_oe), 0);
    checkOutput("midrst o_valid", int'(o_valid), 0);
    checkOutput("midrst o_data", int'(o_data), 0);
    checkOutput("midrst o_state", int'(o_state), 0);
    checkOutput("midrst o_loop_len", int'(o_loop_len), 0);
    @(negedge clk);
    rst_n = 1'b1;
    i_rec = 1'b0;
    got_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) got_cnt++;
    end
    checkOutput("midrst discarded", got_cnt, 0);
    applyStimulus(0, 1, 42);
    checkOutput("post rst data", got_data, 42);
    checkOutput("post rst state", int'(o_state), 0);
    checkOutput("post rst access", got_acc, 0);

    checkOutput("oe_we overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
